// File: rtl/board_led_shifter.sv
// Serial 96-bit RGB frame shifter for the board's 74HC595 LED chain.
// Define KING_BLINK_EN to blink king squares with period 2*BLINK_DIV.
module board_led_shifter #(
    parameter int CLK_DIV    = 10,
    parameter int GAP_CYCLES = 1000,
    parameter int BLINK_DIV  = 10_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [31:0] playerPieces,
    input  logic [31:0] cpuPieces,
    input  logic [31:0] kingPieces,
    output logic        ser,
    output logic        srclk,
    output logic        rclk,
    output logic        oe_n,
    output logic        busy,
    output logic        frame_done
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_SLO, S_SHI, S_LATCH, S_GAP
    } state_t;

    localparam int CMAX = (2 * CLK_DIV > GAP_CYCLES) ? 2 * CLK_DIV : GAP_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [6:0]    bit_q, bit_d;
    logic [95:0]   sreg_q, sreg_d;
    logic [95:0]   frame;
    logic          blink_on;

    logic ser_q, srclk_q, rclk_q, oe_n_q, busy_q, done_q;
    logic ser_d, srclk_d, rclk_d, oe_n_d, busy_d, done_d;

`ifdef KING_BLINK_EN
    localparam int BW = $clog2(BLINK_DIV + 1);

    logic [BW-1:0] bcnt_q;
    logic          blink_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bcnt_q  <= '0;
            blink_q <= 1'b1;
        end else if (bcnt_q == BW'(BLINK_DIV - 1)) begin
            bcnt_q  <= '0;
            blink_q <= ~blink_q;
        end else begin
            bcnt_q <= bcnt_q + 1'b1;
        end
    end

    assign blink_on = blink_q;
`else
    assign blink_on = (BLINK_DIV != 0);
`endif

    // Square i occupies frame[3i+2:3i] as {R,G,B}; MSB is shifted first.
    always_comb begin
        frame = '0;
        for (int i = 0; i < 32; i++) begin
            if (playerPieces[i] && cpuPieces[i])
                frame[3*i +: 3] = 3'b101;
            else if (playerPieces[i])
                frame[3*i +: 3] = {2'b01, kingPieces[i] & blink_on};
            else if (cpuPieces[i])
                frame[3*i +: 3] = {1'b1, kingPieces[i] & blink_on, 1'b0};
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        sreg_d  = sreg_q;
        unique case (state_q)
            S_IDLE: begin
                if (en) begin
                    state_d = S_LOAD;
                    cnt_d   = '0;
                end
            end
            S_LOAD: begin
                state_d = S_SLO;
                cnt_d   = '0;
                bit_d   = '0;
                sreg_d  = frame;
            end
            S_SLO: begin
                if (cnt_q == CW'(CLK_DIV - 1)) begin
                    state_d = S_SHI;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_SHI: begin
                if (cnt_q == CW'(CLK_DIV - 1)) begin
                    cnt_d = '0;
                    if (bit_q == 7'd95) begin
                        state_d = S_LATCH;
                    end else begin
                        state_d = S_SLO;
                        bit_d   = bit_q + 7'd1;
                        sreg_d  = {sreg_q[94:0], 1'b0};
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_LATCH: begin
                if (cnt_q == CW'(2 * CLK_DIV - 1)) begin
                    state_d = S_GAP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_GAP: begin
                if (cnt_q == CW'(GAP_CYCLES - 1)) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Strobes are decoded from the next state so they register in step with it.
    always_comb begin
        ser_d   = (state_d == S_SLO || state_d == S_SHI) && sreg_d[95];
        srclk_d = (state_d == S_SHI);
        rclk_d  = (state_d == S_LATCH) && (cnt_d >= CW'(CLK_DIV));
        busy_d  = (state_d == S_LOAD) || (state_d == S_SLO) ||
                  (state_d == S_SHI)  || (state_d == S_LATCH);
        done_d  = (state_d == S_LATCH) && (cnt_d == CW'(2 * CLK_DIV - 1));
        oe_n_d  = oe_n_q && !done_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            sreg_q  <= '0;
            ser_q   <= 1'b0;
            srclk_q <= 1'b0;
            rclk_q  <= 1'b0;
            oe_n_q  <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sreg_q  <= sreg_d;
            ser_q   <= ser_d;
            srclk_q <= srclk_d;
            rclk_q  <= rclk_d;
            oe_n_q  <= oe_n_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign ser        = ser_q;
    assign srclk      = srclk_q;
    assign rclk       = rclk_q;
    assign oe_n       = oe_n_q;
    assign busy       = busy_q;
    assign frame_done = done_q;

endmodule

// File: tb/tb_board_led_shifter.sv
// Bench for board_led_shifter: random board words against a per-square colour model.
// Frames are captured from ser at srclk rises and compared at each rclk rise.
module tb_board_led_shifter;

    localparam int CD  = 2;
    localparam int GAP = 4;
    localparam int BD  = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic [31:0] pp, cp, kp;
    logic        ser, srclk, rclk, oe_n, busy, frame_done;

    always #5 clk = ~clk;

    board_led_shifter #(
        .CLK_DIV   (CD),
        .GAP_CYCLES(GAP),
        .BLINK_DIV (BD)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .playerPieces(pp),
        .cpuPieces   (cp),
        .kingPieces  (kp),
        .ser         (ser),
        .srclk       (srclk),
        .rclk        (rclk),
        .oe_n        (oe_n),
        .busy        (busy),
        .frame_done  (frame_done)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [95:0] got,
                       input logic [95:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Colour of one square from its occupancy, by the board colour rules.
    function automatic logic [2:0] colour(input logic p, input logic c,
                                          input logic k, input logic bl);
        logic [2:0] rgb;
        if (p && c)  rgb = 3'b101;
        else if (p)  rgb = (k && bl) ? 3'b011 : 3'b010;
        else if (c)  rgb = (k && bl) ? 3'b110 : 3'b100;
        else         rgb = 3'b000;
        return rgb;
    endfunction

    // Expected serial stream, square 31 first, packed first-bit-at-MSB.
    function automatic logic [95:0] model_frame(input logic [31:0] p,
                                                input logic [31:0] c,
                                                input logic [31:0] k,
                                                input logic bl);
        logic [95:0] f = '0;
        for (int sq = 31; sq >= 0; sq--)
            f = {f[92:0], colour(p[sq], c[sq], k[sq], bl)};
        return f;
    endfunction

    function automatic logic model_blink(input int unsigned n);
`ifdef KING_BLINK_EN
        return ((n / BD) % 2) == 0;
`else
        return (n >= 0);
`endif
    endfunction

    int unsigned ncyc = 0;
    always @(posedge clk or negedge reset) begin
        if (!reset) ncyc = 0;
        else        ncyc = ncyc + 1;
    end

    bit          bq[$];
    logic [31:0] sp, sc, sk;
    logic        sb;
    logic [95:0] got;
    logic        ps = 0, pr = 0, pb = 0;
    int          srise = 0, rrise = 0, fdn = 0;

    always @(negedge clk) begin
        if (!reset) begin
            ps = 0; pr = 0; pb = 0;
            bq.delete();
        end else begin
            if (busy && !pb) begin
                sp = pp; sc = cp; sk = kp;
                sb = model_blink(ncyc);
                bq.delete();
            end
            if (srclk && !ps) begin
                bq.push_back(ser);
                srise++;
            end
            if (rclk && !pr) begin
                rrise++;
                got = '0;
                foreach (bq[i]) got = {got[94:0], bq[i]};
                chk("nbits", 96'(bq.size()), 96'd96);
                chk("frame", got, model_frame(sp, sc, sk, sb));
            end
            if (frame_done) begin
                fdn++;
                chk("oe_at_done", 96'(oe_n), 96'd0);
            end
            ps = srclk; pr = rclk; pb = busy;
        end
    end

    task automatic wait_busy(input logic v, input string tag);
        int n = 0;
        while (busy !== v && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 96'(busy === v), 96'd1);
    endtask

    task automatic wait_done(input string tag);
        int f0 = fdn;
        int n  = 0;
        while (fdn == f0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 96'(fdn != f0), 96'd1);
    endtask

    task automatic run_frame(input logic [31:0] p, input logic [31:0] c,
                             input logic [31:0] k);
        wait_busy(1'b0, "to_idle");
        pp = p; cp = c; kp = k;
        en = 1'b1;
        wait_busy(1'b1, "to_load");
        wait_done("done");
    endtask

    initial begin
        int s0;
        int n;
        reset = 1'b0;
        en    = 1'b0;
        pp = '0; cp = '0; kp = '0;
        repeat (3) @(negedge clk);
        chk("rst_ser",   96'(ser),        96'd0);
        chk("rst_srclk", 96'(srclk),      96'd0);
        chk("rst_rclk",  96'(rclk),       96'd0);
        chk("rst_oe_n",  96'(oe_n),       96'd1);
        chk("rst_busy",  96'(busy),       96'd0);
        chk("rst_done",  96'(frame_done), 96'd0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        run_frame(32'h1, 32'h0, 32'h0);
        @(negedge clk);
        chk("oe_after", 96'(oe_n), 96'd0);

        run_frame(32'h0, 32'h8000_0000, 32'h8000_0001);
        run_frame(32'h0, 32'h8000_0000, 32'h8000_0001);

        run_frame(32'h0, 32'h0, 32'h0);
        wait_busy(1'b0, "t4_idle");
        pp = 32'h0; cp = 32'h0; kp = 32'h0;
        wait_busy(1'b1, "t4_load");
        repeat (5) @(negedge clk);
        cp = 32'hFFFF_FFFF;
        wait_done("t4_old");
        wait_busy(1'b0, "t4_gap");
        wait_busy(1'b1, "t4_load2");
        wait_done("t4_new");

        for (int i = 0; i < 10; i++)
            run_frame($urandom, $urandom & $urandom, $urandom);

`ifdef KING_BLINK_EN
        for (int i = 0; i < 5; i++)
            run_frame(32'h1, 32'h0, 32'h1);
`endif

        wait_busy(1'b0, "t5_idle");
        pp = $urandom | 32'h20;
        cp = ($urandom & 32'h0F0F_0F0F) | 32'h20;
        kp = $urandom;
        en = 1'b1;
        wait_busy(1'b1, "t5_load");
        n = 0;
        while (bq.size() < 40 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("t5_bit40", 96'(bq.size() >= 40), 96'd1);
        en = 1'b0;
        wait_done("t5_done");
        s0 = srise;
        repeat (1000) @(negedge clk);
        chk("t5_no_srclk", 96'(srise - s0), 96'd0);
        chk("t5_busy",     96'(busy),       96'd0);
        chk("t5_oe_n",     96'(oe_n),       96'd0);

        wait_busy(1'b0, "t1_idle");
        pp = $urandom; cp = $urandom; kp = $urandom;
        en = 1'b1;
        n = 0;
        while (bq.size() < 10 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("t1_ser",   96'(ser),        96'd0);
        chk("t1_srclk", 96'(srclk),      96'd0);
        chk("t1_rclk",  96'(rclk),       96'd0);
        chk("t1_busy",  96'(busy),       96'd0);
        chk("t1_oe_n",  96'(oe_n),       96'd1);
        chk("t1_done",  96'(frame_done), 96'd0);
        en = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        s0 = srise;
        repeat (1000) @(negedge clk);
        chk("t1_no_srclk", 96'(srise - s0), 96'd0);
        chk("t1_oe_hold",  96'(oe_n),       96'd1);
        chk("done_vs_rclk", 96'(fdn), 96'(rrise));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
